// File: rtl/keypad_entry_loader.sv
// keypad_entry_loader: watches the keypad shift register, counts entered
// digits, validates the four-digit HHMM entry on a load button and emits a
// one-cycle load strobe (or an error pulse), then blanks the keypad.
module keypad_entry_loader #(
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd500_000_000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] keypad_values,
  input  logic        shift_pulse,
  input  logic        load_time_btn,
  input  logic        load_alarm_btn,
  input  logic        cancel_btn,
  output logic        reset_shift,
  output logic        time_load,
  output logic        alarm_load,
  output logic [15:0] load_value,
  output logic [2:0]  digit_count,
  output logic        entry_error
);

  typedef enum logic [2:0] {
    IDLE,
    ENTRY,
    CHECK,
    LOAD,
    ERROR,
    CLEAR
  } state_t;

  state_t      state;
  state_t      next_state;

  // Bit order of the conditioned inputs: {cancel, alarm, time, shift}
  logic [3:0]  raw_in;
  logic [3:0]  sync1;
  logic [3:0]  sync2;
  logic [3:0]  sync_prev;
  logic [3:0]  edges;

  logic        digit_ev;
  logic        time_ev;
  logic        alarm_ev;
  logic        cancel_ev;

  logic        started;
  logic        req_alarm;
  logic        req_alarm_nx;
  logic [2:0]  count_nx;
  logic [31:0] timer;
  logic [31:0] timer_nx;
  logic        latch_value;
  logic        entry_valid;

  logic [3:0]  h_tens;
  logic [3:0]  h_units;
  logic [3:0]  m_tens;
  logic [3:0]  m_units;

  assign raw_in    = {cancel_btn, load_alarm_btn, load_time_btn, shift_pulse};
  assign edges     = sync2 & ~sync_prev;
  assign digit_ev  = edges[0];
  assign time_ev   = edges[1];
  assign alarm_ev  = edges[2];
  assign cancel_ev = edges[3];

  assign h_tens  = keypad_values[15:12];
  assign h_units = keypad_values[11:8];
  assign m_tens  = keypad_values[7:4];
  assign m_units = keypad_values[3:0];

  // An entry is loadable only with four digits forming a legal 24-hour HHMM time
  assign entry_valid = (digit_count == 3'd4) &&
                       (h_tens <= 4'd9) && (h_units <= 4'd9) &&
                       (m_tens <= 4'd9) && (m_units <= 4'd9) &&
                       (h_tens <= 4'd2) &&
                       ((h_tens != 4'd2) || (h_units <= 4'd3)) &&
                       (m_tens <= 4'd5);

  // Two-flop synchronizers plus a delayed copy for rising-edge detection
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1     <= 4'b0000;
      sync2     <= 4'b0000;
      sync_prev <= 4'b0000;
    end else begin
      sync1     <= raw_in;
      sync2     <= sync1;
      sync_prev <= sync2;
    end
  end

  // State, counters and the latched load request/value
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= CLEAR;
      started     <= 1'b0;
      req_alarm   <= 1'b0;
      digit_count <= 3'd0;
      timer       <= 32'd0;
      load_value  <= 16'h0000;
    end else begin
      state       <= next_state;
      started     <= 1'b1;
      req_alarm   <= req_alarm_nx;
      digit_count <= count_nx;
      timer       <= timer_nx;
      if (latch_value) begin
        load_value <= keypad_values;
      end
    end
  end

  // Next-state logic; inside ENTRY cancel beats load, and load beats digit
  always_comb begin
    next_state   = state;
    count_nx     = digit_count;
    timer_nx     = 32'd0;
    req_alarm_nx = req_alarm;
    latch_value  = 1'b0;
    case (state)
      IDLE: begin
        count_nx = 3'd0;
        if (cancel_ev) begin
          next_state = CLEAR;
        end else if (time_ev || alarm_ev) begin
          next_state = ERROR;
        end else if (digit_ev) begin
          next_state = ENTRY;
          count_nx   = 3'd1;
        end
      end
      ENTRY: begin
        if (cancel_ev) begin
          next_state = CLEAR;
        end else if (time_ev && alarm_ev) begin
          next_state = ERROR;
        end else if (time_ev || alarm_ev) begin
          next_state   = CHECK;
          req_alarm_nx = alarm_ev;
        end else if (digit_ev) begin
          count_nx = (digit_count == 3'd4) ? 3'd4 : digit_count + 3'd1;
        end else if (timer == TIMEOUT_CYCLES - 32'd1) begin
          next_state = ERROR;
        end else begin
          timer_nx = timer + 32'd1;
        end
      end
      CHECK: begin
        if (entry_valid) begin
          next_state  = LOAD;
          latch_value = 1'b1;
        end else begin
          next_state = ERROR;
        end
      end
      LOAD:  next_state = CLEAR;
      ERROR: next_state = CLEAR;
      CLEAR: begin
        count_nx = 3'd0;
        // Hold CLEAR for the first cycle out of reset so the keypad gets blanked
        if (started) begin
          next_state = IDLE;
        end
      end
      default: next_state = CLEAR;
    endcase
    if (next_state == CLEAR) begin
      count_nx = 3'd0;
    end
  end

  // Strobes decode directly from the registered state
  always_comb begin
    reset_shift = started && (state == CLEAR);
    time_load   = (state == LOAD) && !req_alarm;
    alarm_load  = (state == LOAD) && req_alarm;
    entry_error = (state == ERROR);
  end

endmodule

// File: tb/tb_keypad_entry_loader.sv
// Self-checking bench for keypad_entry_loader: directed scenarios followed by
// randomized entries checked against a transaction-level reference model.
module tb_keypad_entry_loader;

  logic        clk;
  logic        reset_n;
  logic [15:0] keypad_values;
  logic        shift_pulse;
  logic        load_time_btn;
  logic        load_alarm_btn;
  logic        cancel_btn;
  logic        reset_shift;
  logic        time_load;
  logic        alarm_load;
  logic [15:0] load_value;
  logic [2:0]  digit_count;
  logic        entry_error;

  int          cmp_count;
  int          fail_count;
  logic [15:0] exp_lv;

  localparam int KIND_TIME   = 0;
  localparam int KIND_ALARM  = 1;
  localparam int KIND_BOTH   = 2;
  localparam int KIND_CANCEL = 3;

  keypad_entry_loader #(.TIMEOUT_CYCLES(32'd16)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .keypad_values  (keypad_values),
    .shift_pulse    (shift_pulse),
    .load_time_btn  (load_time_btn),
    .load_alarm_btn (load_alarm_btn),
    .cancel_btn     (cancel_btn),
    .reset_shift    (reset_shift),
    .time_load      (time_load),
    .alarm_load     (alarm_load),
    .load_value     (load_value),
    .digit_count    (digit_count),
    .entry_error    (entry_error)
  );

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case the bench ever hangs
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmp_count++;
    if (obs !== exp) begin
      fail_count++;
      $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Legal 24-hour time check written in plain arithmetic
  function automatic bit time_ok(input logic [15:0] v);
    int d[4];
    d[0] = int'(v[15:12]);
    d[1] = int'(v[11:8]);
    d[2] = int'(v[7:4]);
    d[3] = int'(v[3:0]);
    for (int i = 0; i < 4; i++) begin
      if (d[i] > 9) return 1'b0;
    end
    return ((d[0] * 10 + d[1]) < 24) && ((d[2] * 10 + d[3]) < 60);
  endfunction

  // Emulates the keypad: shift a digit in, pulse, then verify the count
  task automatic send_digit(input logic [3:0] d, input int expected_count);
    int w;
    @(negedge clk);
    keypad_values = {keypad_values[11:0], d};
    shift_pulse   = 1'b1;
    w = $urandom_range(1, 3);
    repeat (w) @(negedge clk);
    shift_pulse = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("digit_count", 32'(digit_count), 32'(expected_count));
  endtask

  // One complete entry: n digits (left-aligned in seq) then a button action
  task automatic applyStimulus(input logic [23:0] seq, input int n, input int kind);
    int          n_time, n_alarm, n_err, n_rs;
    int          k_strobe, k_err, k_rs;
    logic [15:0] lv_at;
    logic [15:0] exp_val;
    bit          exp_load, exp_is_alarm;
    int          exp_err_k, exp_rs_k;
    n_time = 0; n_alarm = 0; n_err = 0; n_rs = 0;
    k_strobe = 0; k_err = 0; k_rs = 0; lv_at = 16'h0;
    for (int i = 0; i < n; i++) begin
      send_digit(seq[23 - 4 * i -: 4], (i + 1 > 4) ? 4 : i + 1);
    end

    // Reference expectations from the entry rules
    exp_val = 16'h0000;
    if (n >= 4) begin
      for (int i = n - 4; i < n; i++) exp_val = {exp_val[11:0], seq[23 - 4 * i -: 4]};
    end
    exp_load     = (kind == KIND_TIME || kind == KIND_ALARM) && (n >= 4) && time_ok(exp_val);
    exp_is_alarm = (kind == KIND_ALARM);
    exp_err_k    = 0;
    if (kind == KIND_CANCEL) begin
      exp_rs_k = 3;
    end else if (kind == KIND_BOTH || n == 0) begin
      exp_err_k = 3;
      exp_rs_k  = 4;
    end else if (exp_load) begin
      exp_rs_k = 5;
    end else begin
      exp_err_k = 4;
      exp_rs_k  = 5;
    end

    @(negedge clk);
    load_time_btn  = (kind == KIND_TIME || kind == KIND_BOTH);
    load_alarm_btn = (kind == KIND_ALARM || kind == KIND_BOTH);
    cancel_btn     = (kind == KIND_CANCEL);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (time_load)   begin n_time++;  k_strobe = k; lv_at = load_value; end
      if (alarm_load)  begin n_alarm++; k_strobe = k; lv_at = load_value; end
      if (entry_error) begin n_err++;   k_err = k; end
      if (reset_shift) begin n_rs++;    k_rs = k; end
    end
    load_time_btn  = 1'b0;
    load_alarm_btn = 1'b0;
    cancel_btn     = 1'b0;

    checkOutput("time_load_count",  32'(n_time),  32'((exp_load && !exp_is_alarm) ? 1 : 0));
    checkOutput("alarm_load_count", 32'(n_alarm), 32'((exp_load && exp_is_alarm) ? 1 : 0));
    checkOutput("error_count",      32'(n_err),   32'((exp_err_k != 0) ? 1 : 0));
    checkOutput("reset_shift_count", 32'(n_rs),   32'd1);
    checkOutput("reset_shift_cycle", 32'(k_rs),   32'(exp_rs_k));
    if (exp_load) begin
      exp_lv = exp_val;
      checkOutput("strobe_cycle", 32'(k_strobe), 32'd4);
      checkOutput("strobe_value", 32'(lv_at),    32'(exp_val));
    end
    if (exp_err_k != 0) begin
      checkOutput("error_cycle", 32'(k_err), 32'(exp_err_k));
    end
    checkOutput("load_value_held", 32'(load_value), 32'(exp_lv));
    checkOutput("count_cleared",   32'(digit_count), 32'd0);
    keypad_values = 16'hAAAA;
    repeat (4) @(negedge clk);
  endtask

  // One digit then silence: error after exactly 16 cycles spent in ENTRY
  task automatic run_timeout;
    int k_one, k_err, k_rs;
    k_one = -1; k_err = -1; k_rs = -1;
    @(negedge clk);
    keypad_values = {keypad_values[11:0], 4'h7};
    shift_pulse   = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (k == 2) shift_pulse = 1'b0;
      if (digit_count == 3'd1 && k_one < 0) k_one = k;
      if (entry_error && k_err < 0) k_err = k;
      if (reset_shift && k_rs < 0) k_rs = k;
    end
    checkOutput("timeout_entered", 32'(k_one >= 0), 32'd1);
    checkOutput("timeout_cycles",  32'(k_err - k_one), 32'd16);
    checkOutput("timeout_clear",   32'(k_rs - k_err), 32'd1);
    checkOutput("timeout_lv_held", 32'(load_value), 32'(exp_lv));
    keypad_values = 16'hAAAA;
    repeat (4) @(negedge clk);
  endtask

  // Valid time load interrupted by reset while the strobe is up
  task automatic run_reset_in_load;
    send_digit(4'h1, 1);
    send_digit(4'h2, 2);
    send_digit(4'h3, 3);
    send_digit(4'h4, 4);
    @(negedge clk);
    load_time_btn = 1'b1;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1;
    checkOutput("load_before_reset", 32'(time_load), 32'd1);
    reset_n = 1'b0;
    #1;
    checkOutput("rst_time_load",   32'(time_load),   32'd0);
    checkOutput("rst_alarm_load",  32'(alarm_load),  32'd0);
    checkOutput("rst_entry_error", 32'(entry_error), 32'd0);
    checkOutput("rst_reset_shift", 32'(reset_shift), 32'd0);
    checkOutput("rst_load_value",  32'(load_value),  32'd0);
    checkOutput("rst_digit_count", 32'(digit_count), 32'd0);
    load_time_btn = 1'b0;
    exp_lv = 16'h0000;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    checkOutput("rerelease_shift_on", 32'(reset_shift), 32'd1);
    @(negedge clk);
    checkOutput("rerelease_shift_off", 32'(reset_shift), 32'd0);
    keypad_values = 16'hAAAA;
    repeat (4) @(negedge clk);
  endtask

  // Random entry generator: usually a legal time, sometimes corrupted
  task automatic random_entry;
    logic [23:0] seq;
    int          n, h, m, r, kind;
    logic [3:0]  tail[4];
    n = $urandom_range(0, 6);
    h = $urandom_range(0, 23);
    m = $urandom_range(0, 59);
    tail[0] = 4'(h / 10);
    tail[1] = 4'(h % 10);
    tail[2] = 4'(m / 10);
    tail[3] = 4'(m % 10);
    if ($urandom_range(0, 3) == 0) tail[$urandom_range(0, 3)] = 4'($urandom_range(0, 15));
    seq = 24'h0;
    for (int i = 0; i < n; i++) begin
      if (i >= n - 4 && n >= 4) seq[23 - 4 * i -: 4] = tail[i - (n - 4)];
      else seq[23 - 4 * i -: 4] = 4'($urandom_range(0, 9));
    end
    r = $urandom_range(0, 9);
    if (r <= 3) kind = KIND_TIME;
    else if (r <= 7) kind = KIND_ALARM;
    else if (r == 8) kind = KIND_BOTH;
    else kind = KIND_CANCEL;
    applyStimulus(seq, n, kind);
  endtask

  // Main sequence: power-up reset, directed cases, random traffic, summary
  initial begin
    cmp_count      = 0;
    fail_count     = 0;
    exp_lv         = 16'h0000;
    reset_n        = 1'b0;
    keypad_values  = 16'hAAAA;
    shift_pulse    = 1'b0;
    load_time_btn  = 1'b0;
    load_alarm_btn = 1'b0;
    cancel_btn     = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_reset_shift", 32'(reset_shift), 32'd0);
    checkOutput("reset_time_load",   32'(time_load),   32'd0);
    checkOutput("reset_alarm_load",  32'(alarm_load),  32'd0);
    checkOutput("reset_entry_error", 32'(entry_error), 32'd0);
    checkOutput("reset_load_value",  32'(load_value),  32'd0);
    checkOutput("reset_digit_count", 32'(digit_count), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    checkOutput("powerup_shift_on", 32'(reset_shift), 32'd1);
    checkOutput("powerup_no_error", 32'(entry_error), 32'd0);
    @(negedge clk);
    checkOutput("powerup_shift_off", 32'(reset_shift), 32'd0);
    repeat (3) @(negedge clk);

    $display("[TB] directed scenarios");
    applyStimulus(24'h123400, 4, KIND_TIME);
    applyStimulus(24'h240000, 4, KIND_ALARM);
    applyStimulus(24'h235900, 4, KIND_ALARM);
    applyStimulus(24'h120000, 2, KIND_TIME);
    applyStimulus(24'h570930, 6, KIND_TIME);
    applyStimulus(24'h123400, 4, KIND_BOTH);
    applyStimulus(24'h120000, 2, KIND_CANCEL);
    applyStimulus(24'h000000, 0, KIND_TIME);
    applyStimulus(24'h000000, 0, KIND_CANCEL);
    applyStimulus(24'h196000, 4, KIND_TIME);
    run_timeout();
    run_reset_in_load();

    $display("[TB] randomized entries");
    for (int t = 0; t < 40; t++) random_entry();

    $display("End of test - %0d assertions evaluated, %0d failures", cmp_count, fail_count);
    $finish;
  end

endmodule

// File: doc/keypad_entry_loader.md
# keypad_entry_loader

Consumer side of the keypad digit-entry interface. It watches the keypad's 16-bit BCD shift value and its shift pulse, and counts entered digits. On a load-time or load-alarm button it validates the four digits as HHMM and emits a one-cycle load strobe with the latched value. It then clears the keypad shift register through `reset_shift`. It sits between the keypad block and the clock/alarm time registers.

## Interface
- `TIMEOUT_CYCLES`, default 32'd500_000_000: idle cycles in ENTRY before entry is abandoned.
- `clk` in 1: system clock; all logic on rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `keypad_values` in 16: four BCD nibbles from the keypad, [15:12]=H tens … [3:0]=M units; 4'hA = blank.
- `shift_pulse` in 1: keypad digit-shifted pulse, asynchronous to `clk`; may be narrower than or wider than one `clk` period.
- `load_time_btn` in 1: level, asynchronous; rising edge requests a time load.
- `load_alarm_btn` in 1: level, asynchronous; rising edge requests an alarm load.
- `cancel_btn` in 1: level, asynchronous; rising edge abandons entry.
- `reset_shift` out 1: one-cycle pulse that blanks the keypad value to 16'hAAAA.
- `time_load` out 1: one-cycle strobe; `load_value` is valid for time.
- `alarm_load` out 1: one-cycle strobe; `load_value` is valid for alarm.
- `load_value` out 16: latched validated HHMM BCD.
- `digit_count` out 3: digits entered since the last clear, saturating at 4.
- `entry_error` out 1: one-cycle pulse on a rejected load or on timeout.

## Operation
- Input conditioning:
  - All four asynchronous inputs pass through 2-flop synchronizers plus a rising-edge detector.
  - Each detected edge is one internal event.
- States:
  - IDLE: `digit_count`=0.
    - Digit event → ENTRY, count=1.
    - Load edge → ERROR.
    - Cancel → CLEAR.
  - ENTRY:
    - Digit event → count+1, saturating at 4; timeout counter cleared.
    - Load edge (exactly one of time/alarm) → CHECK.
    - Both load edges in the same cycle → ERROR.
    - Cancel → CLEAR.
    - Timeout counter reaches TIMEOUT_CYCLES-1 → ERROR.
  - CHECK (1 cycle): samples `keypad_values`. The entry is valid only if all of the following hold; valid → LOAD with the value latched into `load_value`, otherwise → ERROR.
    - count==4.
    - Every nibble ≤9.
    - H tens ≤2.
    - H tens==2 implies H units ≤3.
    - M tens ≤5.
  - LOAD (1 cycle): `time_load` or `alarm_load` =1, per the latched request type → CLEAR.
  - ERROR (1 cycle): `entry_error`=1 → CLEAR.
  - CLEAR (1 cycle): `reset_shift`=1, count←0 → IDLE.
- Priority inside ENTRY, in the same cycle: cancel > load > digit.
  - A digit event coinciding with a load edge is not counted.
  - CHECK still samples whatever `keypad_values` holds.
- Events arriving in CHECK/LOAD/ERROR/CLEAR are discarded, not queued.
- More than 4 digits: count stays 4; the keypad retains the last four digits, and those are what gets checked.
- `load_value` holds its value until the next successful CHECK; ERROR does not alter it.

## Timing
- Reset values:
  - `reset_shift`=0, `time_load`=0, `alarm_load`=0, `entry_error`=0.
  - `load_value`=16'h0000, `digit_count`=0.
  - Synchronizers and timeout counter=0.
  - state=CLEAR.
- First cycle after `reset_n` deasserts: `reset_shift`=1, then IDLE. The keypad is therefore blanked at power-up.
- Reset asserted mid-operation: immediate return to the reset values; any pending strobe is lost.
- Digit latency: `digit_count` updates 3 `clk` edges after the `shift_pulse` rising edge (2 sync + 1 edge register).
- Load latency, from the first clk edge after the button rises:
  - CHECK is entered after 3 edges.
  - Load strobe on edge 4.
  - `reset_shift` on edge 5.
  - IDLE on edge 6.
- Error latency: `entry_error` 1 cycle after CHECK (or after the offending event), `reset_shift` the next cycle.
- Strobes are exactly one cycle wide and mutually exclusive.
- Timeout counter: 32-bit, counts only in ENTRY, wraps never (the transition to ERROR occurs first).

## Test plan
- Reset release → `reset_shift` high for exactly one cycle, all other outputs 0, `digit_count`=0.
- Digits 1,2,3,4 (`keypad_values`=16'h1234), then `load_time_btn` → `time_load` 1 cycle with `load_value`=16'h1234, `alarm_load`=0, `reset_shift` next cycle, `digit_count`=0.
- Digits 2,4,0,0 then `load_alarm_btn` → `entry_error` pulse, no load strobe, `load_value` unchanged. Repeat with 2,3,5,9 → `alarm_load`, `load_value`=16'h2359.
- Two digits (16'hAA12) then `load_time_btn` → `entry_error`. Six digits ending 0,9,3,0 → `digit_count` saturates at 4; load gives 16'h0930.
- `load_time_btn` and `load_alarm_btn` rising in the same cycle during ENTRY → `entry_error`; `cancel_btn` during ENTRY → `reset_shift`, no error.
- TIMEOUT_CYCLES=16, one digit, then idle → `entry_error` after 16 cycles in ENTRY, then `reset_shift`. `reset_n` asserted during LOAD → no strobe, outputs at reset values.
